// File: rtl/reg_view_ctrl.sv
// rtl/reg_view_ctrl.sv - register-file viewer with button stepping, auto-repeat and auto-scan
module reg_view_ctrl #(
    parameter int NREGS       = 32,
    parameter int DW          = 32,
    parameter int SCAN_DIV    = 50_000_000,
    parameter int REPEAT_DLY  = 25_000_000,
    parameter int REPEAT_RATE = 5_000_000,
    localparam int IW         = $clog2(NREGS)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NREGS*DW-1:0] regs_flat_i,
    input  logic                btn_next_i,
    input  logic                btn_prev_i,
    input  logic                auto_en_i,
    input  logic                freeze_i,
    output logic [IW-1:0]       sel_idx_o,
    output logic [DW-1:0]       data_sel_o,
    output logic                step_o
);

    localparam int HMAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
    localparam int HW   = $clog2(HMAX + 1);
    localparam int SW   = $clog2(SCAN_DIV);

    typedef enum logic {ST_MANUAL = 1'b0, ST_AUTO = 1'b1} state_t;

    state_t        state_q, state_d;
    logic [1:0]    btn_raw;
    logic [1:0]    btn_s1_q, btn_s2_q, btn_s3_q;
    logic          auto_s1_q, auto_s2_q;
    logic [HW-1:0] hold_cnt_q [2];
    logic [HW-1:0] hold_cnt_d [2];
    logic [1:0]    rep_q, rep_d;
    logic [1:0]    req;
    logic [SW-1:0] scan_q, scan_d;
    logic [IW-1:0] sel_idx_q, sel_idx_d, idx_inc, idx_dec;
    logic [DW-1:0] data_sel_q, data_sel_d, word;
    logic          step_q, step_d;

    assign btn_raw = {btn_prev_i, btn_next_i};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            btn_s1_q      <= '0;
            btn_s2_q      <= '0;
            btn_s3_q      <= '0;
            auto_s1_q     <= 1'b0;
            auto_s2_q     <= 1'b0;
            hold_cnt_q[0] <= '0;
            hold_cnt_q[1] <= '0;
            rep_q         <= '0;
        end else begin
            btn_s1_q      <= btn_raw;
            btn_s2_q      <= btn_s1_q;
            btn_s3_q      <= btn_s2_q;
            auto_s1_q     <= auto_en_i;
            auto_s2_q     <= auto_s1_q;
            hold_cnt_q[0] <= hold_cnt_d[0];
            hold_cnt_q[1] <= hold_cnt_d[1];
            rep_q         <= rep_d;
        end
    end

    // Channel 0 = next, 1 = prev. The hold counter runs to REPEAT_DLY once,
    // then restarts and runs to REPEAT_RATE for every following repeat.
    always_comb begin
        for (int c = 0; c < 2; c++) begin
            req[c]        = 1'b0;
            rep_d[c]      = 1'b0;
            hold_cnt_d[c] = '0;
            if (btn_s2_q[c]) begin
                rep_d[c]      = rep_q[c];
                hold_cnt_d[c] = hold_cnt_q[c] + HW'(1);
                if (!rep_q[c] && hold_cnt_q[c] == HW'(REPEAT_DLY)) begin
                    req[c]        = 1'b1;
                    rep_d[c]      = 1'b1;
                    hold_cnt_d[c] = HW'(1);
                end else if (rep_q[c] && hold_cnt_q[c] == HW'(REPEAT_RATE)) begin
                    req[c]        = 1'b1;
                    hold_cnt_d[c] = HW'(1);
                end
                if (!btn_s3_q[c]) begin
                    req[c] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_MANUAL;
            scan_q     <= '0;
            sel_idx_q  <= '0;
            data_sel_q <= '0;
            step_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            scan_q     <= scan_d;
            sel_idx_q  <= sel_idx_d;
            data_sel_q <= data_sel_d;
            step_q     <= step_d;
        end
    end

    assign idx_inc = (sel_idx_q == IW'(NREGS - 1)) ? '0 : sel_idx_q + IW'(1);
    assign idx_dec = (sel_idx_q == '0) ? IW'(NREGS - 1) : sel_idx_q - IW'(1);

    always_comb begin
        state_d   = state_q;
        scan_d    = scan_q;
        sel_idx_d = sel_idx_q;
        step_d    = 1'b0;
        case (state_q)
            ST_MANUAL: begin
                scan_d = '0;
                if (auto_s2_q) begin
                    state_d = ST_AUTO;
                end
            end
            ST_AUTO: begin
                // Any button activity restarts the scan period and swallows a coincident tick.
                if (|req) begin
                    scan_d = '0;
                end else if (scan_q == SW'(SCAN_DIV - 1)) begin
                    scan_d    = '0;
                    sel_idx_d = idx_inc;
                    step_d    = 1'b1;
                end else begin
                    scan_d = scan_q + SW'(1);
                end
                if (!auto_s2_q) begin
                    state_d = ST_MANUAL;
                end
            end
            default: state_d = ST_MANUAL;
        endcase
        if (req[0] && !req[1]) begin
            sel_idx_d = idx_inc;
            step_d    = 1'b1;
        end else if (req[1] && !req[0]) begin
            sel_idx_d = idx_dec;
            step_d    = 1'b1;
        end
    end

    always_comb begin
        word = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (sel_idx_q == IW'(i)) begin
                word = regs_flat_i[i*DW +: DW];
            end
        end
        data_sel_d = freeze_i ? data_sel_q : word;
    end

    assign sel_idx_o  = sel_idx_q;
    assign data_sel_o = data_sel_q;
    assign step_o     = step_q;

endmodule
